hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 32, number of cycles an iterative multiply/divide op occupies EX.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 Rs1_D, Rs2_D  input  5 each  source register indices of the instruction in decode.
REQ-005 Rs1_E, Rs2_E, RD_E  input  5 each  source and destination register indices in execute.
REQ-006 RD_M, RD_W  input  5 each  destination register indices in memory and writeback.
REQ-007 RegWriteM, RegWriteW  input  1 each  register-write enables in memory and writeback.
REQ-008 ResultSrcE  input  1  1 = the instruction in execute is a load.
REQ-009 PCSrcE  input  1  1 = taken branch resolved in execute.
REQ-010 MdReqE  input  1  1 = the instruction in execute is a multi-cycle mul/div op.
REQ-011 ForwardA_E, ForwardB_E  output  2 each  operand select: 00 register file, 01 ResultW, 10 ALU_ResultM.
REQ-012 StallF, StallD, StallE  output  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-013 FlushD, FlushE, FlushM  output  1 each  bubble IF/ID, ID/EX and EX/MEM.
REQ-014 MdStart  output  1  one-cycle pulse launching the iterative unit; MdBusy  output  1  FSM not IDLE.

Function
REQ-015 ForwardA_E SHALL be 10 when RegWriteM, RD_M!=0 and RD_M==Rs1_E; else 01 when RegWriteW, RD_W!=0 and RD_W==Rs1_E; else 00. ForwardB_E is identical using Rs2_E.
REQ-016 When M and W both match, M (10) SHALL win; register x0 is never forwarded.
REQ-017 Load-use: ResultSrcE=1, RD_E!=0 and RD_E equals Rs1_D or Rs2_D SHALL assert StallF, StallD and FlushE in the same cycle.
REQ-018 Branch: PCSrcE=1 SHALL assert FlushD and FlushE and suppress the load-use stall in that cycle.
REQ-019 The FSM SHALL have states IDLE, BUSY and DONE, with a 6-bit down-counter.
REQ-020 IDLE -> BUSY when MdReqE=1: MdStart pulses for one cycle and the counter loads MD_CYCLES-1.
REQ-021 In BUSY the counter SHALL decrement each cycle; BUSY -> DONE when the counter reaches 0.
REQ-022 DONE -> IDLE after one cycle; MdReqE is ignored in DONE, so the same op is never relaunched.
REQ-023 In IDLE with MdReqE=1, and throughout BUSY, StallF, StallD and StallE SHALL be 1 and FlushM SHALL be 1; in DONE all stalls are 0 and the op advances.
REQ-024 MdReqE with a simultaneous load-use match SHALL behave as the mul/div stall only (FlushE=0).
REQ-025 Stall and flush outputs other than those listed SHALL be 0; stall and flush logic is combinational from inputs and state.
REQ-026 Stall-to-release latency SHALL be exactly MD_CYCLES+1 cycles from the MdStart edge.

Reset
REQ-027 While rst=0 the FSM SHALL be IDLE, the counter 0, and MdStart and MdBusy 0.
REQ-028 Reset asserted mid-BUSY SHALL abort the op immediately; no DONE is produced.
REQ-029 Forward outputs are not affected by reset; they follow their inputs.

Structure
REQ-030 Forward encodings (FWD_RF, FWD_WB, FWD_MEM), FSM state encodings and MD_CYCLES belong in a shared pipeline package.
REQ-031 The FSM and counter SHALL live in one sub-module, md_sequencer; forwarding and hazard detection stay in the top level.

Verification
REQ-032 RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1, Rs1_E=5 -> ForwardA_E=10; then RegWriteM=0 -> ForwardA_E=01.
REQ-033 RD_M=0, RegWriteM=1, Rs2_E=0 -> ForwardB_E=00.
REQ-034 ResultSrcE=1, RD_E=7, Rs2_D=7 -> StallF=StallD=FlushE=1; add PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
REQ-035 MdReqE=1 held with MD_CYCLES=32 -> exactly one MdStart pulse, stalls held for 33 cycles, DONE in the following cycle, then IDLE.
REQ-036 rst=0 asserted 10 cycles into BUSY -> IDLE, MdBusy=0 and stalls released without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants: operand-forward selects, mul/div sequencer states
// and the default iterative mul/div occupancy.
package hazard_ctrl_pkg;

   localparam int MD_CYCLES = 32;
   localparam int CNT_W     = 6;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // The younger producer (memory stage) wins; x0 is never forwarded.
   function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                             input logic [4:0] rd_m, input logic wr_m,
                                             input logic [4:0] rd_w, input logic wr_w);
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// Iterative mul/div sequencer: IDLE -> BUSY (down-counter) -> DONE -> IDLE,
// producing the launch pulse and the stall request for the hazard unit.
module md_sequencer
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_CYCLES = hazard_ctrl_pkg::MD_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic md_req,
   output logic md_start,
   output logic md_busy,
   output logic md_stall
);

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (md_req) begin
               state_next = ST_BUSY;
               cnt_next   = CNT_W'(MD_CYCLES - 1);
            end
         end
         ST_BUSY: begin
            if (cnt_reg == '0)
               state_next = ST_DONE;
            else
               cnt_next = cnt_reg - CNT_W'(1);
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Gated by rst so a held request cannot launch or stall while in reset.
   assign md_start = rst && (state_reg == ST_IDLE) && md_req;
   assign md_busy  = (state_reg != ST_IDLE);
   assign md_stall = md_start || (rst && (state_reg == ST_BUSY));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX operand forwarding, load-use stall, branch flush
// and the multi-cycle mul/div stall driven by md_sequencer.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_CYCLES = hazard_ctrl_pkg::MD_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] Rs1_D,
   input  logic [4:0] Rs2_D,
   input  logic [4:0] Rs1_E,
   input  logic [4:0] Rs2_E,
   input  logic [4:0] RD_E,
   input  logic [4:0] RD_M,
   input  logic [4:0] RD_W,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       ResultSrcE,
   input  logic       PCSrcE,
   input  logic       MdReqE,
   output logic [1:0] ForwardA_E,
   output logic [1:0] ForwardB_E,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushM,
   output logic       MdStart,
   output logic       MdBusy
);

   logic [4:0] rs_e     [2];
   logic [1:0] fwd_sel  [2];
   logic       md_stall;
   logic       load_use;
   logic       lu_stall;

   assign rs_e[0] = Rs1_E;
   assign rs_e[1] = Rs2_E;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd_sel[gi] = fwd_select(rs_e[gi], RD_M, RegWriteM, RD_W, RegWriteW);
      end
   endgenerate

   assign ForwardA_E = fwd_sel[0];
   assign ForwardB_E = fwd_sel[1];

   md_sequencer #(
      .MD_CYCLES (MD_CYCLES)
   ) u_md_seq (
      .clk      (clk),
      .rst      (rst),
      .md_req   (MdReqE),
      .md_start (MdStart),
      .md_busy  (MdBusy),
      .md_stall (md_stall)
   );

   assign load_use = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
   // A taken branch squashes the dependent instruction; a mul/div stall already holds it.
   assign lu_stall = load_use && !PCSrcE && !md_stall;

   assign StallF = lu_stall || md_stall;
   assign StallD = lu_stall || md_stall;
   assign StallE = md_stall;
   assign FlushD = PCSrcE;
   assign FlushE = PCSrcE || lu_stall;
   assign FlushM = md_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random inputs, all checked
// against a cycle-position model of the mul/div op and rule-level hazard model.
module tb_hazard_ctrl;

   localparam int MDC = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
   logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MdReqE;
   logic [1:0] ForwardA_E, ForwardB_E;
   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdStart, MdBusy;

   int total = 0;
   int bad   = 0;
   int op_pos = -1;      // -1: no op; 1..MDC: busy cycle index; MDC+1: done cycle
   int starts = 0;
   int stall_cycles = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MD_CYCLES(MDC)) dut (
      .clk(clk), .rst(rst),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdReqE(MdReqE),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .MdStart(MdStart), .MdBusy(MdBusy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'd2;
      if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'd1;
      return 2'd0;
   endfunction

   task automatic check_all(input string tag);
      logic md_st, start_e, busy_e, lu, lu_e;
      if (!rst) begin
         md_st = 0; start_e = 0; busy_e = 0;
      end else if (op_pos < 0) begin
         md_st = MdReqE; start_e = MdReqE; busy_e = 0;
      end else if (op_pos <= MDC) begin
         md_st = 1; start_e = 0; busy_e = 1;
      end else begin
         md_st = 0; start_e = 0; busy_e = 1;
      end
      lu   = ResultSrcE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
      lu_e = lu && !PCSrcE && !md_st;
      $display("%s: fA=%0d fB=%0d stall=%b%b%b flush=%b%b%b start=%b busy=%b", tag,
               ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               MdStart, MdBusy);
      if (MdStart === 1'b1) starts++;
      if (StallE === 1'b1) stall_cycles++;
      chk({tag, ".ForwardA_E"}, 32'(ForwardA_E), 32'(ref_fwd(Rs1_E)));
      chk({tag, ".ForwardB_E"}, 32'(ForwardB_E), 32'(ref_fwd(Rs2_E)));
      chk({tag, ".StallF"},  32'(StallF),  32'(lu_e | md_st));
      chk({tag, ".StallD"},  32'(StallD),  32'(lu_e | md_st));
      chk({tag, ".StallE"},  32'(StallE),  32'(md_st));
      chk({tag, ".FlushD"},  32'(FlushD),  32'(PCSrcE));
      chk({tag, ".FlushE"},  32'(FlushE),  32'(PCSrcE | lu_e));
      chk({tag, ".FlushM"},  32'(FlushM),  32'(md_st));
      chk({tag, ".MdStart"}, 32'(MdStart), 32'(start_e));
      chk({tag, ".MdBusy"},  32'(MdBusy),  32'(busy_e));
   endtask

   // Check at the falling edge, advance the op position at the rising edge.
   task automatic tick(input string tag);
      @(negedge clk);
      check_all(tag);
      @(posedge clk);
      if (!rst)                 op_pos = -1;
      else if (op_pos < 0)      op_pos = MdReqE ? 1 : -1;
      else if (op_pos <= MDC)   op_pos = op_pos + 1;
      else                      op_pos = -1;
      #1;
   endtask

   task automatic clear_inputs();
      Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MdReqE = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      #1 rst = 1'b0;
      #1 check_all("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1; Rs1_E = 5;
      tick("fwd_mem_wins");
      RegWriteM = 0;
      tick("fwd_wb");
      clear_inputs(); RD_M = 0; RegWriteM = 1; Rs2_E = 0;
      tick("fwd_x0");
      clear_inputs(); ResultSrcE = 1; RD_E = 7; Rs2_D = 7;
      tick("load_use");
      PCSrcE = 1;
      tick("branch_over_lu");

      // Held mul/div request overlapping a load-use match.
      clear_inputs(); ResultSrcE = 1; RD_E = 7; Rs1_D = 7; MdReqE = 1;
      starts = 0; stall_cycles = 0;
      tick("md_launch");
      ResultSrcE = 0;
      for (int i = 0; i < MDC; i++) tick("md_busy");
      tick("md_done");
      MdReqE = 0;
      tick("md_idle");
      chk("md_start_pulses", 32'(starts), 32'd1);
      chk("md_stall_cycles", 32'(stall_cycles), 32'(MDC + 1));

      // Asynchronous reset 10 cycles into BUSY with the request still held.
      MdReqE = 1;
      tick("md_launch2");
      repeat (10) tick("md_busy2");
      #2 rst = 1'b0;
      op_pos = -1;
      #1 check_all("async_rst");
      tick("rst_hold");
      rst = 1'b1; MdReqE = 0;
      tick("after_rst");

      for (int i = 0; i < 300; i++) begin
         Rs1_D = 5'($urandom_range(0, 7)); Rs2_D = 5'($urandom_range(0, 7));
         Rs1_E = 5'($urandom_range(0, 7)); Rs2_E = 5'($urandom_range(0, 7));
         RD_E  = 5'($urandom_range(0, 7)); RD_M  = 5'($urandom_range(0, 7));
         RD_W  = 5'($urandom_range(0, 7));
         RegWriteM  = 1'($urandom_range(0, 1));
         RegWriteW  = 1'($urandom_range(0, 1));
         ResultSrcE = 1'($urandom_range(0, 1));
         PCSrcE     = ($urandom_range(0, 3) == 0);
         MdReqE     = (op_pos < 0) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
